// File: rtl/fpu_cmd_sequencer.sv
// rtl/fpu_cmd_sequencer.sv - round-robin command sequencer driving the byte-wide FPU register bus
module fpu_cmd_sequencer #(
   parameter int RD_WAIT = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_op_a,
   input  logic [63:0] req_op_b,
   input  logic [15:0] req_op,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_error,
   output logic [3:0]  fpu_addr,
   output logic [7:0]  fpu_wdata,
   input  logic [7:0]  fpu_rdata,
   output logic        fpu_cs_n,
   output logic        fpu_rd_n,
   output logic        fpu_wr_n,
   output logic        fpu_end_ack,
   input  logic        fpu_cmd_end,
   output logic        busy
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

   typedef enum logic [2:0] {IDLE, WRITE, WAIT_END, READ, ACK, RESP} state_t;
   state_t state, state_nx;

   logic [31:0]   op_a, op_b;
   logic [7:0]    op;
   logic          gnt, last;
   logic [3:0]    acc;      // write access 0..9, then read byte 0..3
   logic [1:0]    phase;
   logic [RW-1:0] rwait;
   logic [TW-1:0] wcnt;
   logic          to_pulse;

   logic       any_req, gnt_nx, write_done, read_last, read_done, timeout_hit, accept;
   logic [7:0] wr_byte;

   always_comb begin
      state_nx    = state;
      fpu_cs_n    = 1'b1;
      fpu_rd_n    = 1'b1;
      fpu_wr_n    = 1'b1;
      fpu_addr    = 4'd0;
      fpu_wdata   = 8'd0;
      fpu_end_ack = to_pulse;
      rsp_valid   = 2'b00;
      busy        = (state != IDLE);
      any_req     = |req_valid;
      // on contention the requester not served last wins
      gnt_nx      = req_valid[1] & (~req_valid[0] | ~last);
      write_done  = (acc == 4'd9) && (phase == 2'd2);
      read_last   = (rwait == RW'(RD_WAIT - 1));
      read_done   = read_last && (acc == 4'd3);
      timeout_hit = (wcnt == TW'(TIMEOUT - 1));
      accept      = rsp_ready[gnt];
      if (acc < 4'd4)
         wr_byte = op_a[{acc[1:0], 3'b000} +: 8];
      else if (acc < 4'd8)
         wr_byte = op_b[{acc[1:0], 3'b000} +: 8];
      else if (acc == 4'd8)
         wr_byte = op;
      else
         wr_byte = 8'd0;

      case (state)
         IDLE: begin
            if (any_req) state_nx = WRITE;
         end
         WRITE: begin
            fpu_cs_n  = 1'b0;
            fpu_addr  = acc;
            fpu_wdata = wr_byte;
            fpu_wr_n  = (phase != 2'd1);
            if (write_done) state_nx = WAIT_END;
         end
         WAIT_END: begin
            if (fpu_cmd_end)      state_nx = READ;
            else if (timeout_hit) state_nx = RESP;
         end
         READ: begin
            fpu_cs_n = 1'b0;
            fpu_rd_n = 1'b0;
            fpu_addr = 4'd9 + acc;
            if (read_done) state_nx = ACK;
         end
         ACK: begin
            fpu_end_ack = 1'b1;
            if (!fpu_cmd_end) state_nx = RESP;
         end
         RESP: begin
            rsp_valid[gnt] = 1'b1;
            if (accept) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state      <= IDLE;
         req_ready  <= 2'b00;
         op_a       <= 32'd0;
         op_b       <= 32'd0;
         op         <= 8'd0;
         gnt        <= 1'b0;
         last       <= 1'b1;
         acc        <= 4'd0;
         phase      <= 2'd0;
         rwait      <= '0;
         wcnt       <= '0;
         to_pulse   <= 1'b0;
         rsp_result <= 32'd0;
         rsp_error  <= 1'b0;
      end else begin
         state     <= state_nx;
         req_ready <= 2'b00;
         to_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  gnt       <= gnt_nx;
                  req_ready <= gnt_nx ? 2'b10 : 2'b01;
                  op_a      <= gnt_nx ? req_op_a[63:32] : req_op_a[31:0];
                  op_b      <= gnt_nx ? req_op_b[63:32] : req_op_b[31:0];
                  op        <= gnt_nx ? req_op[15:8]    : req_op[7:0];
                  acc       <= 4'd0;
                  phase     <= 2'd0;
               end
            end
            WRITE: begin
               wcnt  <= '0;
               rwait <= '0;
               if (phase == 2'd2) begin
                  phase <= 2'd0;
                  acc   <= write_done ? 4'd0 : acc + 4'd1;
               end else begin
                  phase <= phase + 2'd1;
               end
            end
            WAIT_END: begin
               wcnt <= wcnt + TW'(1);
               if (!fpu_cmd_end && timeout_hit) begin
                  rsp_error  <= 1'b1;
                  rsp_result <= 32'd0;
                  to_pulse   <= 1'b1;
               end
            end
            READ: begin
               if (read_last) begin
                  rsp_result[{acc[1:0], 3'b000} +: 8] <= fpu_rdata;
                  rwait <= '0;
                  acc   <= acc + 4'd1;
               end else begin
                  rwait <= rwait + RW'(1);
               end
            end
            RESP: begin
               if (accept) begin
                  rsp_error <= 1'b0;
                  last      <= gnt;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb/tb_fpu_cmd_sequencer.sv - table-driven bench for fpu_cmd_sequencer with a behavioural FPU model
module tb_fpu_cmd_sequencer;
   localparam int RD_WAIT = 2;
   localparam int TO      = 24;
   localparam int END_DLY = 20;
   localparam int ACK_DLY = 5;

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [63:0] req_op_a = 64'd0;
   logic [63:0] req_op_b = 64'd0;
   logic [15:0] req_op = 16'd0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = 2'b00;
   logic [31:0] rsp_result;
   logic        rsp_error;
   logic [3:0]  fpu_addr;
   logic [7:0]  fpu_wdata;
   logic [7:0]  fpu_rdata;
   logic        fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack, busy;
   logic        fpu_cmd_end;

   always #5 clk = ~clk;

   fpu_cmd_sequencer #(.RD_WAIT(RD_WAIT), .TIMEOUT(TO)) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_error(rsp_error),
      .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata),
      .fpu_cs_n(fpu_cs_n), .fpu_rd_n(fpu_rd_n), .fpu_wr_n(fpu_wr_n),
      .fpu_end_ack(fpu_end_ack), .fpu_cmd_end(fpu_cmd_end), .busy(busy)
   );

   // FPU model: logs writes, raises cmd_end after the start write, drops it ACK_DLY cycles into end_ack
   logic [31:0] fpu_res = 32'd0;
   logic        no_end = 1'b0;
   int          end_dly, ack_cnt;
   logic [3:0]  wlog_addr[$];
   logic [7:0]  wlog_data[$];

   always_comb begin
      case (fpu_addr)
         4'd9:    fpu_rdata = fpu_res[7:0];
         4'd10:   fpu_rdata = fpu_res[15:8];
         4'd11:   fpu_rdata = fpu_res[23:16];
         4'd12:   fpu_rdata = fpu_res[31:24];
         default: fpu_rdata = 8'd0;
      endcase
   end

   always @(posedge clk or negedge arst) begin
      if (!arst) begin
         fpu_cmd_end <= 1'b0;
         end_dly     <= 0;
         ack_cnt     <= 0;
      end else begin
         if (!fpu_cs_n && !fpu_wr_n) begin
            wlog_addr.push_back(fpu_addr);
            wlog_data.push_back(fpu_wdata);
         end
         if (!fpu_cs_n && !fpu_wr_n && fpu_addr == 4'd9) begin
            end_dly <= END_DLY;
         end else if (end_dly > 0) begin
            end_dly <= end_dly - 1;
            if (end_dly == 1 && !no_end) fpu_cmd_end <= 1'b1;
         end
         if (fpu_end_ack && fpu_cmd_end) begin
            ack_cnt <= ack_cnt + 1;
            if (ack_cnt + 1 == ACK_DLY) fpu_cmd_end <= 1'b0;
         end else if (!fpu_end_ack) begin
            ack_cnt <= 0;
         end
      end
   end

   int wcyc = 0, rdcyc = 0, ackcyc = 0, viol = 0;
   always @(negedge clk) begin
      if (!fpu_cs_n && fpu_rd_n) wcyc++;
      if (!fpu_rd_n) rdcyc++;
      if (fpu_end_ack) ackcyc++;
      if (!fpu_rd_n && !fpu_wr_n) viol++;
      if (fpu_end_ack && !fpu_cs_n) viol++;
   end

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] onehot(input int r);
      return 32'(1) << r;
   endfunction

   typedef struct {
      int          r;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  op;
      logic [31:0] res;
   } vec_t;
   vec_t vecs[4];

   task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
      req_op_a[32*r +: 32] = a;
      req_op_b[32*r +: 32] = b;
      req_op[8*r +: 8]     = op;
      req_valid[r]         = 1'b1;
   endtask

   task automatic wait_ready(input int r);
      int n;
      for (n = 0; n < 100 && req_ready == 2'b00; n++) @(negedge clk);
      chk("ready_wait", 32'(n < 100), 32'd1);
      chk("req_ready", 32'(req_ready), onehot(r));
   endtask

   task automatic wait_rsp();
      int n;
      for (n = 0; n < 400 && rsp_valid == 2'b00; n++) @(negedge clk);
      chk("rsp_wait", 32'(n < 400), 32'd1);
   endtask

   task automatic accept(input int r);
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready[r] = 1'b0;
   endtask

   task automatic run_cmd(input vec_t v);
      int ws, ac0, wc0, rc0;
      logic [7:0] eb;
      ws = wlog_addr.size(); ac0 = ackcyc; wc0 = wcyc; rc0 = rdcyc;
      fpu_res = v.res;
      drive_req(v.r, v.a, v.b, v.op);
      wait_ready(v.r);
      @(negedge clk);
      req_valid[v.r] = 1'b0;
      wait_rsp();
      chk("rsp_valid", 32'(rsp_valid), onehot(v.r));
      chk("rsp_result", rsp_result, v.res);
      chk("rsp_error", 32'(rsp_error), 32'd0);
      chk("ack_low_at_rsp", 32'(fpu_end_ack), 32'd0);
      chk("ack_cycles", 32'(ackcyc - ac0), 32'(ACK_DLY + 1));
      accept(v.r);
      chk("rsp_cleared", 32'(rsp_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("write_cycles", 32'(wcyc - wc0), 32'd30);
      chk("read_cycles", 32'(rdcyc - rc0), 32'(4 * RD_WAIT));
      chk("write_count", 32'(wlog_addr.size() - ws), 32'd10);
      if (wlog_addr.size() - ws == 10) begin
         for (int i = 0; i < 10; i++) begin
            if (i < 4)       eb = v.a[8*i +: 8];
            else if (i < 8)  eb = v.b[8*(i-4) +: 8];
            else if (i == 8) eb = v.op;
            else             eb = 8'h00;
            chk("write_addr", 32'(wlog_addr[ws+i]), 32'(i));
            chk("write_data", 32'(wlog_data[ws+i]), 32'(eb));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r_arb[2];
      int n;
      logic seen;

      vecs[0] = '{0, 32'h40490fda, 32'h402df854, 8'h02, 32'h3f5b89c6};
      vecs[1] = '{1, 32'hc0000000, 32'h3f800000, 8'h01, 32'hc0400000};
      vecs[2] = '{0, 32'h12345678, 32'h9abcdef0, 8'h03, 32'h00ff00ff};
      vecs[3] = '{0, 32'hffffffff, 32'h00000000, 8'h04, 32'h80000001};
      r_arb[0] = 32'h40400000;
      r_arb[1] = 32'h3f400000;

      // both requesters valid from reset onwards
      drive_req(0, 32'h3f800000, 32'h40000000, 8'h01);
      drive_req(1, 32'h40400000, 32'h40800000, 8'h02);
      @(negedge clk); @(negedge clk);
      chk("rst_cs_n", 32'(fpu_cs_n), 32'd1);
      chk("rst_rd_n", 32'(fpu_rd_n), 32'd1);
      chk("rst_wr_n", 32'(fpu_wr_n), 32'd1);
      chk("rst_addr", 32'(fpu_addr), 32'd0);
      chk("rst_wdata", 32'(fpu_wdata), 32'd0);
      chk("rst_end_ack", 32'(fpu_end_ack), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_error", 32'(rsp_error), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      arst = 1'b1;

      for (int k = 0; k < 4; k++) begin
         wait_ready(k % 2);
         fpu_res = r_arb[k % 2];
         if (k == 3) begin
            @(negedge clk);
            req_valid = 2'b00;
         end
         wait_rsp();
         chk("arb_rsp_valid", 32'(rsp_valid), onehot(k % 2));
         chk("arb_rsp_result", rsp_result, r_arb[k % 2]);
         accept(k % 2);
      end
      repeat (3) @(negedge clk);
      chk("arb_done_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 4; i++) run_cmd(vecs[i]);

      // timeout: cmd_end never raised
      no_end  = 1'b1;
      fpu_res = 32'hdeadbeef;
      drive_req(1, 32'h11111111, 32'h22222222, 8'h05);
      wait_ready(1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      for (n = 0; n < 100 && !(!fpu_cs_n && !fpu_wr_n && fpu_addr == 4'd9); n++) @(negedge clk);
      chk("to_start_seen", 32'(n < 100), 32'd1);
      @(negedge clk);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         if (fpu_end_ack) break;
         n++;
      end
      chk("to_wait_cycles", 32'(n), 32'(TO));
      chk("to_ack_cs_n", 32'(fpu_cs_n), 32'd1);
      chk("to_rsp_valid", 32'(rsp_valid), 32'b10);
      chk("to_rsp_error", 32'(rsp_error), 32'd1);
      chk("to_rsp_result", rsp_result, 32'd0);
      @(negedge clk);
      chk("to_ack_pulse", 32'(fpu_end_ack), 32'd0);
      chk("to_error_held", 32'(rsp_error), 32'd1);
      accept(1);
      chk("to_error_clr", 32'(rsp_error), 32'd0);
      no_end = 1'b0;
      run_cmd(vecs[0]);

      // reset during the write to address 5
      fpu_res = vecs[2].res;
      drive_req(0, vecs[2].a, vecs[2].b, vecs[2].op);
      wait_ready(0);
      @(negedge clk);
      req_valid[0] = 1'b0;
      for (n = 0; n < 100 && !(!fpu_cs_n && fpu_addr == 4'd5); n++) @(negedge clk);
      chk("abort_addr5_seen", 32'(n < 100), 32'd1);
      arst = 1'b0;
      #1;
      chk("abort_cs_n", 32'(fpu_cs_n), 32'd1);
      chk("abort_wr_n", 32'(fpu_wr_n), 32'd1);
      chk("abort_rd_n", 32'(fpu_rd_n), 32'd1);
      chk("abort_addr", 32'(fpu_addr), 32'd0);
      chk("abort_wdata", 32'(fpu_wdata), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", rsp_result, 32'd0);
      @(negedge clk);
      arst = 1'b1;
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (rsp_valid != 2'b00 || busy) seen = 1'b1;
      end
      chk("abort_no_rsp", 32'(seen), 32'd0);
      run_cmd(vecs[1]);

      chk("protocol_violations", 32'(viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
